// File: rtl/job_dispatcher_rr.sv
// job_dispatcher_rr: pulls 1024-bit job descriptors, starts each on an idle
// kernel chosen round-robin, remembers {pid, jobid} per kernel and returns it
// to the completion queue through a round-robin completion arbiter.
// Optional per-kernel watchdog: define JOB_SCHED_TIMEOUT_EN to build it.
module job_dispatcher_rr #(
    parameter int          KERNEL_NUM     = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  dsc0_pull_o,
    input  logic                  dsc0_ready_i,
    input  logic [1023:0]         dsc0_data_i,
    input  logic                  complete_ready_i,
    output logic                  complete_push_o,
    output logic [40:0]           return_data_o,
    output logic                  complete_err_o,
    output logic [KERNEL_NUM-1:0] engine_start,
    output logic [1023:0]         jd_payload,
    input  logic [KERNEL_NUM-1:0] engine_done,
    output logic [KERNEL_NUM-1:0] kernel_busy_o,
    output logic [5:0]            jobs_inflight_o
);

    localparam int PW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;

    // {pid, jobid} of the job running on a kernel
    typedef logic [40:0] info_t;

    // First candidate at or after ptr, wrapping around the kernel array.
    function automatic logic [PW-1:0] rr_pick(input logic [KERNEL_NUM-1:0] cand,
                                              input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx;
        logic          hit;
        int            s;
        pick = '0;
        hit  = 1'b0;
        for (int i = 0; i < KERNEL_NUM; i++) begin
            s = int'(ptr) + i;
            if (s >= KERNEL_NUM) s = s - KERNEL_NUM;
            idx = PW'(s);
            if (!hit && cand[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
        int s;
        s = int'(g) + 1;
        if (s >= KERNEL_NUM) s = 0;
        return PW'(s);
    endfunction

    logic [KERNEL_NUM-1:0] busy_q, busy_d;
    logic [KERNEL_NUM-1:0] done_pending_q, done_pending_d;
    logic [KERNEL_NUM-1:0] engine_start_q, engine_start_d;
    logic [PW-1:0]         dsc_ptr_q, dsc_ptr_d;
    logic [PW-1:0]         cpl_ptr_q, cpl_ptr_d;
    logic [1023:0]         jd_payload_q, jd_payload_d;
    info_t                 info_q [KERNEL_NUM];
    info_t                 info_d [KERNEL_NUM];

    logic                  dsc_pull;
    logic                  cpl_push;
    logic [PW-1:0]         dsc_g;
    logic [PW-1:0]         cpl_g;
    logic [KERNEL_NUM-1:0] cpl_req;

    // Low descriptor word carries nothing this block needs.
    logic dsc_lo_unused;
    assign dsc_lo_unused = ^dsc0_data_i[31:0];

`ifdef JOB_SCHED_TIMEOUT_EN
    logic [KERNEL_NUM-1:0] timeout_q, timeout_d;
    logic [31:0]           cnt_q [KERNEL_NUM];
    logic [31:0]           cnt_d [KERNEL_NUM];
`else
    localparam logic [31:0] TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

    // Handshake decode and both round-robin grants
    always_comb begin
        dsc_pull = dsc0_ready_i & ~(&busy_q) & ~(|engine_start_q);
        dsc_g    = rr_pick(~busy_q, dsc_ptr_q);
        cpl_req  = done_pending_q & busy_q;
        cpl_g    = rr_pick(cpl_req, cpl_ptr_q);
        cpl_push = (|cpl_req) & complete_ready_i;
    end

    // Next-state for kernel tracking, pointers, start pulse and payload
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // this block leaves one unassigned and no latch is inferred.
        busy_d         = busy_q;
        engine_start_d = '0;
        jd_payload_d   = jd_payload_q;
        dsc_ptr_d      = dsc_ptr_q;
        cpl_ptr_d      = cpl_ptr_q;
        info_d         = info_q;
        // Done on an idle kernel, or in its start cycle, is dropped.
        done_pending_d = done_pending_q | (engine_done & busy_q & ~engine_start_q);
`ifdef JOB_SCHED_TIMEOUT_EN
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (busy_q[k] && !done_pending_q[k]) begin
                cnt_d[k] = cnt_q[k] + 32'd1;
                if (cnt_q[k] == TIMEOUT_CYCLES - 32'd1) begin
                    timeout_d[k]      = 1'b1;
                    done_pending_d[k] = 1'b1;
                end
            end
        end
`endif
        if (cpl_push) begin
            busy_d[cpl_g]         = 1'b0;
            done_pending_d[cpl_g] = 1'b0;
            cpl_ptr_d             = next_ptr(cpl_g);
`ifdef JOB_SCHED_TIMEOUT_EN
            timeout_d[cpl_g]      = 1'b0;
`endif
        end
        if (dsc_pull) begin
            busy_d[dsc_g]         = 1'b1;
            done_pending_d[dsc_g] = 1'b0;
            info_d[dsc_g]         = {dsc0_data_i[1000:992], dsc0_data_i[63:32]};
            dsc_ptr_d             = next_ptr(dsc_g);
            engine_start_d[dsc_g] = 1'b1;
            jd_payload_d          = {dsc0_data_i[63:32], dsc0_data_i[1023:64],
                                     dsc0_data_i[1023:992]};
`ifdef JOB_SCHED_TIMEOUT_EN
            timeout_d[dsc_g]      = 1'b0;
            cnt_d[dsc_g]          = '0;
`endif
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples
        // the pre-edge value regardless of statement order.
        if (!rst_n) begin
            busy_q         <= '0;
            done_pending_q <= '0;
            engine_start_q <= '0;
            dsc_ptr_q      <= '0;
            cpl_ptr_q      <= '0;
            jd_payload_q   <= '0;
            // NOTE: the slot table is small and must read as zero after
            // reset, so it is cleared like ordinary flops, not left as RAM.
            for (int k = 0; k < KERNEL_NUM; k++) info_q[k] <= '0;
`ifdef JOB_SCHED_TIMEOUT_EN
            timeout_q <= '0;
            for (int k = 0; k < KERNEL_NUM; k++) cnt_q[k] <= '0;
`endif
        end else begin
            busy_q         <= busy_d;
            done_pending_q <= done_pending_d;
            engine_start_q <= engine_start_d;
            dsc_ptr_q      <= dsc_ptr_d;
            cpl_ptr_q      <= cpl_ptr_d;
            jd_payload_q   <= jd_payload_d;
            info_q         <= info_d;
`ifdef JOB_SCHED_TIMEOUT_EN
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Output drive and busy population count
    always_comb begin
        dsc0_pull_o     = dsc_pull;
        complete_push_o = cpl_push;
        return_data_o   = cpl_push ? info_q[cpl_g] : '0;
`ifdef JOB_SCHED_TIMEOUT_EN
        complete_err_o  = cpl_push & timeout_q[cpl_g];
`else
        complete_err_o  = 1'b0;
`endif
        engine_start    = engine_start_q;
        jd_payload      = jd_payload_q;
        kernel_busy_o   = busy_q;
        jobs_inflight_o = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            jobs_inflight_o = jobs_inflight_o + 6'(busy_q[k]);
        end
    end

endmodule

// File: tb/tb_job_dispatcher_rr.sv
// Scoreboard bench for job_dispatcher_rr with four kernels and a 16-cycle
// watchdog limit (watchdog expectations follow JOB_SCHED_TIMEOUT_EN).
module tb_job_dispatcher_rr;

    localparam int KN = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dsc0_pull_o;
    logic          dsc0_ready_i;
    logic [1023:0] dsc0_data_i;
    logic          complete_ready_i;
    logic          complete_push_o;
    logic [40:0]   return_data_o;
    logic          complete_err_o;
    logic [KN-1:0] engine_start;
    logic [1023:0] jd_payload;
    logic [KN-1:0] engine_done;
    logic [KN-1:0] kernel_busy_o;
    logic [5:0]    jobs_inflight_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [KN-1:0] start;
        logic [1023:0] payload;
    } start_t;

    typedef struct packed {
        logic        err;
        logic [40:0] data;
    } cpl_t;

    start_t exp_start[$];
    cpl_t   exp_cpl[$];

    job_dispatcher_rr #(
        .KERNEL_NUM     (KN),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dsc0_pull_o      (dsc0_pull_o),
        .dsc0_ready_i     (dsc0_ready_i),
        .dsc0_data_i      (dsc0_data_i),
        .complete_ready_i (complete_ready_i),
        .complete_push_o  (complete_push_o),
        .return_data_o    (return_data_o),
        .complete_err_o   (complete_err_o),
        .engine_start     (engine_start),
        .jd_payload       (jd_payload),
        .engine_done      (engine_done),
        .kernel_busy_o    (kernel_busy_o),
        .jobs_inflight_o  (jobs_inflight_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_payload(input string name, input logic [1023:0] act,
                                 input logic [1023:0] exp);
        int w;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            w = 0;
            for (int i = 31; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
            $display("FAIL %s: word %0d got %h expected %h", name, w,
                     act[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    function automatic logic [1023:0] mk_dsc(input logic [31:0] jobid, input logic [8:0] pid);
        logic [1023:0] d;
        d = {32{jobid ^ 32'h5A5A_0F0F}};
        d[63:32]   = jobid;
        d[1000:992] = pid;
        return d;
    endfunction

    // Start payload: jobid word on top, descriptor bits 1023:64, then the top word.
    function automatic logic [1023:0] exp_payload(input logic [1023:0] d);
        return {d[63:32], d[1023:64], d[1023:992]};
    endfunction

    // Monitor: compares every start and every completion with the scoreboard.
    always @(negedge clk) begin
        start_t es;
        cpl_t   ec;
        if (rst_n === 1'b1) begin
            if (engine_start !== '0) begin
                if (exp_start.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL start_unexpected: got %b expected none", engine_start);
                end else begin
                    es = exp_start.pop_front();
                    check("start_onehot", 64'(engine_start), 64'(es.start));
                    check_payload("start_payload", jd_payload, es.payload);
                end
            end
            if (complete_push_o === 1'b1) begin
                if (exp_cpl.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL cpl_unexpected: got %h expected none", return_data_o);
                end else begin
                    ec = exp_cpl.pop_front();
                    check("cpl_data", {22'd0, complete_err_o, return_data_o}, 64'(ec));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one descriptor, waits for the pull, records the expected start.
    task automatic dispatch(input logic [31:0] jobid, input logic [8:0] pid,
                            input logic [KN-1:0] exp_onehot);
        logic [1023:0] d;
        bit            seen;
        seen = 1'b0;
        d = mk_dsc(jobid, pid);
        dsc0_data_i  = d;
        dsc0_ready_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dsc0_pull_o === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL pull_wait: got no pull expected pull for job %h", jobid);
        end else begin
            exp_start.push_back('{start: exp_onehot, payload: exp_payload(d)});
        end
        @(posedge clk);
        #1;
        dsc0_ready_i = 1'b0;
    endtask

    task automatic expect_cpl(input logic err, input logic [8:0] pid, input logic [31:0] jobid);
        exp_cpl.push_back('{err: err, data: {pid, jobid}});
    endtask

    task automatic pulse_done(input logic [KN-1:0] m);
        engine_done = m;
        @(posedge clk);
        #1;
        engine_done = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no end expected end");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n            = 1'b0;
        dsc0_ready_i     = 1'b0;
        dsc0_data_i      = '0;
        complete_ready_i = 1'b1;
        engine_done      = '0;
        tick(3);

        // Reset state
        @(negedge clk);
        check("rst_pull", 64'(dsc0_pull_o), 0);
        check("rst_push", 64'(complete_push_o), 0);
        check("rst_data", 64'(return_data_o), 0);
        check("rst_err", 64'(complete_err_o), 0);
        check("rst_start", 64'(engine_start), 0);
        check("rst_busy", 64'(kernel_busy_o), 0);
        check("rst_inflight", 64'(jobs_inflight_o), 0);
        check_payload("rst_payload", jd_payload, '0);
        tick(1);
        rst_n = 1'b1;

        // Fill all four kernels in round-robin order
        dispatch(32'hCAFE0001, 9'h1A2, 4'b0001);
        dispatch(32'hA0000001, 9'h101, 4'b0010);
        dispatch(32'hA0000002, 9'h102, 4'b0100);
        dispatch(32'hA0000003, 9'h103, 4'b1000);
        dsc0_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_no_pull", 64'(dsc0_pull_o), 0);
        end
        check("full_inflight", 64'(jobs_inflight_o), 4);
        check("full_busy", 64'(kernel_busy_o), 64'hF);
        tick(1);
        dsc0_ready_i = 1'b0;

        // Kernel 0 done -> push next cycle with its {pid, jobid}
        expect_cpl(1'b0, 9'h1A2, 32'hCAFE0001);
        pulse_done(4'b0001);
        @(negedge clk);
        check("k0_push", 64'(complete_push_o), 1);
        check("k0_data", 64'(return_data_o), 64'h1A2_CAFE0001);
        tick(1);
        check("k0_busy_clear", 64'(kernel_busy_o[0]), 0);

        // Kernel 1 done, leaving the completion pointer at 2
        expect_cpl(1'b0, 9'h101, 32'hA0000001);
        pulse_done(4'b0010);
        tick(2);

        // Refill kernels 0 and 1
        dispatch(32'hB0000000, 9'h0B0, 4'b0001);
        dispatch(32'hB0000001, 9'h0B1, 4'b0010);
        tick(2);

        // Kernels 0, 1, 3 done together -> order 3, 0, 1 back to back
        expect_cpl(1'b0, 9'h103, 32'hA0000003);
        expect_cpl(1'b0, 9'h0B0, 32'hB0000000);
        expect_cpl(1'b0, 9'h0B1, 32'hB0000001);
        pulse_done(4'b1011);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("burst_push", 64'(complete_push_o), 1);
            tick(1);
        end
        @(negedge clk);
        check("burst_end", 64'(complete_push_o), 0);
        check("burst_busy", 64'(kernel_busy_o), 64'h4);

        // Back-pressure on kernel 2
        tick(1);
        complete_ready_i = 1'b0;
        expect_cpl(1'b0, 9'h102, 32'hA0000002);
        pulse_done(4'b0100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_no_push", 64'(complete_push_o), 0);
            check("bp_busy", 64'(kernel_busy_o[2]), 1);
        end
        tick(1);
        complete_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_push", 64'(complete_push_o), 1);
        tick(2);
        check("bp_inflight", 64'(jobs_inflight_o), 0);

        // Done on an idle kernel is ignored
        pulse_done(4'b0010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_done_push", 64'(complete_push_o), 0);
        end
        check("idle_done_busy", 64'(kernel_busy_o), 0);
        tick(1);

        // Done in the start cycle is ignored; a later done retires the job
        dispatch(32'hC0000002, 9'h0C2, 4'b0100);
        pulse_done(4'b0100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("start_done_push", 64'(complete_push_o), 0);
        end
        check("start_done_busy", 64'(kernel_busy_o), 64'h4);
        tick(1);
        expect_cpl(1'b0, 9'h0C2, 32'hC0000002);
        pulse_done(4'b0100);
        tick(3);

        // Watchdog on kernel 3 with no done
`ifdef JOB_SCHED_TIMEOUT_EN
        expect_cpl(1'b1, 9'h0D3, 32'hD0000003);
`endif
        dispatch(32'hD0000003, 9'h0D3, 4'b1000);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("wd_quiet", 64'(complete_push_o), 0);
            tick(1);
        end
        @(negedge clk);
`ifdef JOB_SCHED_TIMEOUT_EN
        check("wd_push", 64'(complete_push_o), 1);
        check("wd_err", 64'(complete_err_o), 1);
`else
        check("wd_absent_push", 64'(complete_push_o), 0);
        check("wd_absent_busy", 64'(kernel_busy_o[3]), 1);
`endif
        tick(2);

        // Reset in mid-operation drops the job; stale done is ignored
        dispatch(32'hE0000000, 9'h0E0, 4'b0001);
        tick(2);
        check_payload("payload_hold", jd_payload, exp_payload(mk_dsc(32'hE0000000, 9'h0E0)));
        engine_done = 4'b0001;
        rst_n       = 1'b0;
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(kernel_busy_o), 0);
        check("mid_rst_inflight", 64'(jobs_inflight_o), 0);
        check("mid_rst_push", 64'(complete_push_o), 0);
        check_payload("mid_rst_payload", jd_payload, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_stale_done", 64'(complete_push_o), 0);
        end
        engine_done = '0;
        tick(5);

        check("start_queue_empty", 64'(exp_start.size()), 0);
        check("cpl_queue_empty", 64'(exp_cpl.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/job_dispatcher_rr.md
# job_dispatcher_rr

Parametrised job dispatcher between the descriptor manager and an array of KERNEL_NUM hardware kernels. It pulls 1024-bit job descriptors, hands each to an idle kernel chosen by round-robin, and tracks per-kernel job identity. When a kernel finishes, it returns {pid, jobid} to the completion queue through a fair round-robin completion arbiter. An optional per-kernel watchdog can be compiled in.

## Interface
- KERNEL_NUM, 8, number of kernels; legal range 1..32
- TIMEOUT_CYCLES, 32'd1_000_000, watchdog limit in clk cycles; used only with the macro
- clk  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- dsc0_pull_o  out  1  descriptor pop strobe; data is consumed in the same cycle
- dsc0_ready_i  in  1  descriptor available
- dsc0_data_i  in  1024  descriptor; jobid = [63:32], pid = [1000:992]
- complete_ready_i  in  1  completion queue can accept
- complete_push_o  out  1  completion write strobe
- return_data_o  out  41  [40:32] pid, [31:0] jobid; 0 when not pushing
- complete_err_o  out  1  completion was forced by the watchdog; qualified by push
- engine_start  out  KERNEL_NUM  one-hot, single-cycle start pulse
- jd_payload  out  1024  payload for the started kernel
- engine_done  in  KERNEL_NUM  per-kernel done pulse or level
- kernel_busy_o  out  KERNEL_NUM  per-kernel busy state
- jobs_inflight_o  out  6  population count of kernel_busy_o

## Operation
- Reset state: all outputs 0. Busy, done_pending, timeout flags and slot info are cleared. Both round-robin pointers are set to 0.
- dsc0_pull_o = dsc0_ready_i & ~&busy & ~|engine_start. This is combinational from registers plus dsc0_ready_i.
- Dispatch grant on a pull:
  - Pick the first idle kernel at or after dsc_ptr, with wrap.
  - At the clock edge: busy[g] <= 1, info[g] <= {dsc[1000:992], dsc[63:32]}, dsc_ptr <= (g+1) mod KERNEL_NUM.
  - Also at that edge: jd_payload <= {dsc[63:32], dsc[1023:64], dsc[1023:992]} and engine_start <= onehot(g).
- jd_payload holds its value until the next pull.
- done_pending[k]:
  - Set when engine_done[k] & busy[k] & ~engine_start[k].
  - Cleared when kernel k completes or starts.
  - engine_done on an idle kernel is ignored.
- Completion arbiter:
  - Request vector: done_pending & busy.
  - Grant c = first requester at or after cpl_ptr, with wrap.
  - complete_push_o = |req & complete_ready_i.
  - return_data_o = info[c] when pushing, else 0.
- On a push: busy[c], done_pending[c] and the timeout flag of c are cleared, and cpl_ptr <= (c+1) mod KERNEL_NUM. If complete_ready_i is low, everything holds.
- A kernel freed by a push in cycle N is dispatch-eligible in cycle N+1.
- Dispatch and completion may occur in the same cycle on different kernels; they are independent.
- KERNEL_NUM=1: both pointers stay 0.

## Timing
- Pull to engine_start/jd_payload: 1 cycle.
- Maximum dispatch rate: one job per 2 cycles, because pull is blocked in the cycle engine_start is high.
- engine_done to complete_push_o: earliest 1 cycle, via the registered done_pending.
- complete_push_o and return_data_o are combinational from registers and complete_ready_i.
- Reset asserted mid-operation: on the next edge all jobs are dropped and no completion is emitted. Outstanding engine_done pulses after reset are ignored.

## Configuration
- JOB_SCHED_TIMEOUT_EN defined:
  - Per-kernel 32-bit counter runs while busy & ~done_pending, and clears on start.
  - When it reaches TIMEOUT_CYCLES-1, the kernel's timeout flag and done_pending are set.
  - The job then retires through the normal arbiter with complete_err_o = 1.
- JOB_SCHED_TIMEOUT_EN undefined: no counters are built and complete_err_o is tied to 0.

## Test plan
- Reset, then dsc0_ready_i=1 with KERNEL_NUM=4 and no dones -> engine_start = 0001, 0010, 0100, 1000 in cycles 2, 4, 6, 8; dsc0_pull_o stays 0 afterwards; jobs_inflight_o=4.
- Descriptor with [63:32]=32'hCAFE0001 and [1000:992]=9'h1A2 to kernel 0, then engine_done[0] pulse -> next cycle complete_push_o=1 and return_data_o=41'h1A2_CAFE0001; busy[0] clears.
- Kernels 0, 1 and 3 done simultaneously, cpl_ptr=2, complete_ready_i=1 -> pushes occur in order 3, 0, 1 on consecutive cycles.
- complete_ready_i=0 for 10 cycles with kernel 2 done -> no push and kernel 2 stays busy; push occurs in the first cycle ready returns.
- engine_done[1] while kernel 1 is idle, and engine_done asserted in the same cycle as engine_start[1] -> both ignored and no completion.
- With the macro and TIMEOUT_CYCLES=16, no engine_done -> push with complete_err_o=1 follows the 16th busy cycle; without the macro, no push occurs.
